// File: rtl/hit_accumulator_bank.sv
// hit_accumulator_bank
// Per-channel saturating hit counters accumulated over a programmed window of
// valid samples. At the end of the window the counts are moved in one step into
// a result bank, and done pulses for one cycle. Software can then read the result
// bank while the next window accumulates.
//
// Ports:
//   clk           rising-edge clock for all logic
//   reset_n       synchronous, active-low reset
//   start         arms one window; sampled only in IDLE and blocked by abort
//   abort         cancels the current window; the result bank is left as it is
//   sample_len    number of valid samples in the window, latched when start is accepted
//   data_valid    qualifies data_in
//   data_in       per-channel hit bits
//   busy          registered; high in ACCUM and DONE
//   done          one-cycle pulse, high when the result bank has just been updated
//   result_valid  high once at least one window has completed
//   rd_sel        channel select for readout
//   rd_data       result[rd_sel], with zero latency; 0 when rd_sel >= CH
//   sat_flags     per-channel saturation flags of the result bank
module hit_accumulator_bank #(
   parameter int CH    = 8,
   parameter int CNT_W = 32,
   parameter int LEN_W = 16,
   parameter int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] sample_len,
   input  logic             data_valid,
   input  logic [CH-1:0]    data_in,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic [CH-1:0]    sat_flags
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};
   localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CH);

   state_t                       state_q, state_d;
   logic [LEN_W-1:0]             len_q, len_d;
   logic [LEN_W-1:0]             cnt_q, cnt_d;
   logic [LEN_W-1:0]             cnt_inc;
   logic [CH-1:0][CNT_W-1:0]     acc_q, acc_d;
   logic [CH-1:0]                sat_q, sat_d;
   logic [CH-1:0][CNT_W-1:0]     result_q, result_d;
   logic [CH-1:0]                sat_flags_q, sat_flags_d;
   logic                         done_q, done_d;
   logic                         result_valid_q, result_valid_d;
   logic                         busy_q, busy_d;

   assign cnt_inc = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

   // Next-state logic for the window FSM, the accumulators and the result bank
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      sat_d          = sat_q;
      result_d       = result_q;
      sat_flags_d    = sat_flags_q;
      done_d         = 1'b0;
      result_valid_d = result_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               len_d = sample_len;
               cnt_d = {LEN_W{1'b0}};
               // A zero-length window skips accumulation and produces zero results
               if (sample_len == {LEN_W{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (abort) begin
               state_d = ST_IDLE;
               acc_d   = {CH{ {CNT_W{1'b0}} }};
               sat_d   = {CH{1'b0}};
            end else if (data_valid) begin
               for (int i = 0; i < CH; i++) begin
                  // Saturate: a hit at full scale holds the count and sets the sticky flag
                  if (data_in[i] && (acc_q[i] == ACC_MAX)) begin
                     acc_d[i] = acc_q[i];
                     sat_d[i] = 1'b1;
                  end else begin
                     acc_d[i] = acc_q[i] + {{(CNT_W-1){1'b0}}, data_in[i]};
                     sat_d[i] = sat_q[i];
                  end
               end
               cnt_d = cnt_inc;
               // The sample that reaches the programmed length is counted in this window
               if (cnt_inc == len_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (abort) begin
               state_d = ST_IDLE;
               acc_d   = {CH{ {CNT_W{1'b0}} }};
               sat_d   = {CH{1'b0}};
            end else begin
               state_d        = ST_IDLE;
               result_d       = acc_q;
               sat_flags_d    = sat_q;
               acc_d          = {CH{ {CNT_W{1'b0}} }};
               sat_d          = {CH{1'b0}};
               done_d         = 1'b1;
               result_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            acc_d   = {CH{ {CNT_W{1'b0}} }};
            sat_d   = {CH{1'b0}};
         end
      endcase

      // busy is registered from the next state so it lines up with ACCUM/DONE
      busy_d = (state_d != ST_IDLE);
   end

   // State and data registers, with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         len_q          <= {LEN_W{1'b0}};
         cnt_q          <= {LEN_W{1'b0}};
         acc_q          <= {CH{ {CNT_W{1'b0}} }};
         sat_q          <= {CH{1'b0}};
         result_q       <= {CH{ {CNT_W{1'b0}} }};
         sat_flags_q    <= {CH{1'b0}};
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         cnt_q          <= cnt_d;
         acc_q          <= acc_d;
         sat_q          <= sat_d;
         result_q       <= result_d;
         sat_flags_q    <= sat_flags_d;
         done_q         <= done_d;
         result_valid_q <= result_valid_d;
         busy_q         <= busy_d;
      end
   end

   // Zero-latency readout mux; selects past the last channel read as zero
   always_comb begin
      if ({1'b0, rd_sel} < CH_LIM) begin
         rd_data = result_q[rd_sel];
      end else begin
         rd_data = {CNT_W{1'b0}};
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = result_valid_q;
   assign sat_flags    = sat_flags_q;

endmodule

// File: tb/tb_hit_accumulator_bank.sv
// Directed bench for hit_accumulator_bank. Two instances share all inputs: the
// main one (CNT_W=32) and a narrow one (CNT_W=2) used for the saturation case.
module tb_hit_accumulator_bank;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [15:0] sample_len;
   logic        data_valid;
   logic [7:0]  data_in;
   logic [2:0]  rd_sel;

   logic        busy, done, result_valid;
   logic [31:0] rd_data;
   logic [7:0]  sat_flags;

   logic        s_busy, s_done, s_result_valid;
   logic [1:0]  s_rd_data;
   logic [7:0]  s_sat_flags;

   int errors = 0;
   int checks = 0;

   hit_accumulator_bank #(.CH(8), .CNT_W(32), .LEN_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .sample_len(sample_len), .data_valid(data_valid), .data_in(data_in),
      .busy(busy), .done(done), .result_valid(result_valid),
      .rd_sel(rd_sel), .rd_data(rd_data), .sat_flags(sat_flags)
   );

   hit_accumulator_bank #(.CH(8), .CNT_W(2), .LEN_W(16)) dut_s (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .sample_len(sample_len), .data_valid(data_valid), .data_in(data_in),
      .busy(s_busy), .done(s_done), .result_valid(s_result_valid),
      .rd_sel(rd_sel), .rd_data(s_rd_data), .sat_flags(s_sat_flags)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string tag);
      rd_sel = sel;
      #1;
      check(tag, {32'd0, rd_data}, {32'd0, exp});
   endtask

   task automatic rd_s(input logic [2:0] sel, input logic [1:0] exp, input string tag);
      rd_sel = sel;
      #1;
      check(tag, {62'd0, s_rd_data}, {62'd0, exp});
   endtask

   task automatic sample(input logic [7:0] d);
      data_valid = 1'b1;
      data_in    = d;
      tick();
      data_valid = 1'b0;
      data_in    = 8'h00;
   endtask

   task automatic arm(input logic [15:0] len);
      start      = 1'b1;
      sample_len = len;
      tick();
      start      = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      sample_len = 16'd0;
      data_valid = 1'b0;
      data_in    = 8'h00;
      rd_sel     = 3'd0;
      tick();
      tick();
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_rv", {63'd0, result_valid}, 64'd0);
      check("rst_sat", {56'd0, sat_flags}, 64'd0);
      rd(3'd0, 32'd0, "rst_rd");
      reset_n = 1'b1;
      tick();

      // Basic window
      arm(16'd4);
      check("basic_busy_accum", {63'd0, busy}, 64'd1);
      sample(8'hFF);
      sample(8'h0F);
      sample(8'h01);
      sample(8'h80);
      check("basic_busy_done_state", {63'd0, busy}, 64'd1);
      check("basic_no_done_early", {63'd0, done}, 64'd0);
      tick();
      check("basic_done", {63'd0, done}, 64'd1);
      check("basic_busy_low", {63'd0, busy}, 64'd0);
      check("basic_rv", {63'd0, result_valid}, 64'd1);
      check("basic_sat", {56'd0, sat_flags}, 64'd0);
      rd(3'd0, 32'd3, "basic_ch0");
      rd(3'd1, 32'd2, "basic_ch1");
      rd(3'd3, 32'd2, "basic_ch3");
      rd(3'd4, 32'd1, "basic_ch4");
      rd(3'd6, 32'd1, "basic_ch6");
      rd(3'd7, 32'd2, "basic_ch7");
      tick();
      check("basic_done_pulse", {63'd0, done}, 64'd0);

      // Saturation on the 2-bit instance
      arm(16'd5);
      repeat (5) sample(8'h04);
      tick();
      check("sat_done", {63'd0, s_done}, 64'd1);
      check("sat_flags_narrow", {56'd0, s_sat_flags}, 64'h04);
      check("sat_flags_wide", {56'd0, sat_flags}, 64'h00);
      rd_s(3'd2, 2'd3, "sat_ch2_narrow");
      rd(3'd2, 32'd5, "sat_ch2_wide");
      rd(3'd0, 32'd0, "sat_ch0_wide");
      tick();

      // Valid gaps: pattern 1,0,1,0,0,1
      arm(16'd3);
      sample(8'h01);
      tick();
      sample(8'h01);
      tick();
      tick();
      sample(8'h01);
      check("gap_no_done_early", {63'd0, done}, 64'd0);
      tick();
      check("gap_done", {63'd0, done}, 64'd1);
      rd(3'd0, 32'd3, "gap_ch0");
      rd(3'd1, 32'd0, "gap_ch1");
      tick();

      // Abort after 4 samples of a 10-sample window
      arm(16'd10);
      repeat (4) sample(8'h01);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_no_done", {63'd0, done}, 64'd0);
      tick();
      check("abort_no_done2", {63'd0, done}, 64'd0);
      check("abort_rv", {63'd0, result_valid}, 64'd1);
      rd(3'd0, 32'd3, "abort_ch0_kept");
      arm(16'd2);
      sample(8'h01);
      sample(8'h01);
      tick();
      check("abort_next_done", {63'd0, done}, 64'd1);
      rd(3'd0, 32'd2, "abort_next_ch0");
      tick();

      // start during ACCUM is ignored
      arm(16'd3);
      start      = 1'b1;
      sample_len = 16'd1;
      sample(8'h01);
      sample(8'h01);
      check("coll_still_busy", {63'd0, busy}, 64'd1);
      check("coll_no_done", {63'd0, done}, 64'd0);
      sample(8'h01);
      start = 1'b0;
      tick();
      check("coll_done", {63'd0, done}, 64'd1);
      rd(3'd0, 32'd3, "coll_ch0");

      // start with abort in IDLE stays IDLE
      start = 1'b1;
      abort = 1'b1;
      sample_len = 16'd2;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("startabort_idle", {63'd0, busy}, 64'd0);
      tick();
      check("startabort_idle2", {63'd0, busy}, 64'd0);

      // Zero-length window
      arm(16'd0);
      check("zero_busy", {63'd0, busy}, 64'd1);
      check("zero_no_done", {63'd0, done}, 64'd0);
      tick();
      check("zero_done", {63'd0, done}, 64'd1);
      rd(3'd0, 32'd0, "zero_ch0");
      rd(3'd7, 32'd0, "zero_ch7");
      tick();

      // Reset mid-window
      arm(16'd4);
      sample(8'hFF);
      sample(8'hFF);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("mrst_busy", {63'd0, busy}, 64'd0);
      check("mrst_done", {63'd0, done}, 64'd0);
      check("mrst_rv", {63'd0, result_valid}, 64'd0);
      check("mrst_sat", {56'd0, sat_flags}, 64'd0);
      rd(3'd0, 32'd0, "mrst_rd");
      arm(16'd2);
      sample(8'h81);
      sample(8'h81);
      tick();
      check("mrst_next_done", {63'd0, done}, 64'd1);
      rd(3'd0, 32'd2, "mrst_next_ch0");
      rd(3'd7, 32'd2, "mrst_next_ch7");
      rd(3'd1, 32'd0, "mrst_next_ch1");
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
